// File: rtl/jpeg_header_gen.sv
// JPEG header byte generator: SOI, DQT, SOF, optional DHT, SOS, then EOI on request.
// Table bytes are prefetched from external synchronous RAM/ROM one cycle ahead of use.
module jpeg_header_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        Start,
   input  logic [15:0] InWidth,
   input  logic [15:0] InHeight,
   input  logic [9:0]  HtLength,
   input  logic        EndRequest,
   output logic [6:0]  QtAddr,
   input  logic [7:0]  QtData,
   output logic [9:0]  HtAddr,
   input  logic [7:0]  HtData,
   output logic [7:0]  OutData,
   output logic        OutEnable,
   input  logic        OutReady,
   output logic        HeaderIdle,
   output logic        HeaderDone,
   output logic        StreamDone
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SOI, ST_DQT, ST_SOF, ST_DHT, ST_SOS, ST_WAIT, ST_EOI
   } state_t;

   state_t      state_r, state_s, next_seg_s;
   logic [10:0] cnt_r, cnt_s, len_s;
   logic [7:0]  out_data_r, out_data_s, byte_s;
   logic        out_en_r, out_en_s, fetched_r;
   logic [6:0]  qt_addr_r, qt_addr_s;
   logic [9:0]  ht_addr_r, ht_addr_s;
   logic [15:0] width_r, height_r;
   logic [9:0]  ht_len_r;
   logic        xfer_s, slot_free_s, tbl_s;

   function automatic logic [10:0] seg_len(input state_t st, input logic [9:0] hl);
      case (st)
         ST_SOI, ST_EOI: seg_len = 11'd2;
         ST_DQT:         seg_len = 11'd134;
         ST_SOF:         seg_len = 11'd19;
         ST_DHT:         seg_len = {1'b0, hl} + 11'd4;
         ST_SOS:         seg_len = 11'd14;
         default:        seg_len = 11'd0;
      endcase
   endfunction

   function automatic logic is_table(input state_t st, input logic [10:0] c, input logic [9:0] hl);
      case (st)
         ST_DQT:  is_table = ((c >= 11'd5) && (c <= 11'd68)) || ((c >= 11'd70) && (c <= 11'd133));
         ST_DHT:  is_table = (c >= 11'd4) && (c < ({1'b0, hl} + 11'd4));
         default: is_table = 1'b0;
      endcase
   endfunction

   // DQT byte index -> RAM address; skips the table-id byte between the two tables
   function automatic logic [6:0] qt_index(input logic [10:0] c);
      logic [10:0] t;
      t = (c < 11'd69) ? (c - 11'd5) : (c - 11'd6);
      qt_index = t[6:0];
   endfunction

   function automatic logic [9:0] ht_index(input logic [10:0] c);
      logic [10:0] t;
      t = c - 11'd4;
      ht_index = t[9:0];
   endfunction

   function automatic logic [7:0] const_byte(input state_t st, input logic [10:0] c,
                                             input logic [15:0] w, input logic [15:0] h,
                                             input logic [9:0] hl);
      logic [15:0] dl;
      dl = {6'd0, hl} + 16'd2;
      case (st)
         ST_SOI: const_byte = (c == 11'd0) ? 8'hFF : 8'hD8;
         ST_EOI: const_byte = (c == 11'd0) ? 8'hFF : 8'hD9;
         ST_DQT:
            case (c)
               11'd0:   const_byte = 8'hFF;
               11'd1:   const_byte = 8'hDB;
               11'd3:   const_byte = 8'h84;
               11'd69:  const_byte = 8'h01;
               default: const_byte = 8'h00;
            endcase
         ST_SOF:
            case (c)
               11'd0:   const_byte = 8'hFF;
               11'd1:   const_byte = 8'hC0;
               11'd3:   const_byte = 8'h11;
               11'd4:   const_byte = 8'h08;
               11'd5:   const_byte = h[15:8];
               11'd6:   const_byte = h[7:0];
               11'd7:   const_byte = w[15:8];
               11'd8:   const_byte = w[7:0];
               11'd9:   const_byte = 8'h03;
               11'd10:  const_byte = 8'h01;
               11'd11:  const_byte = 8'h22;
               11'd13:  const_byte = 8'h02;
               11'd14:  const_byte = 8'h11;
               11'd15:  const_byte = 8'h01;
               11'd16:  const_byte = 8'h03;
               11'd17:  const_byte = 8'h11;
               11'd18:  const_byte = 8'h01;
               default: const_byte = 8'h00;
            endcase
         ST_DHT:
            case (c)
               11'd0:   const_byte = 8'hFF;
               11'd1:   const_byte = 8'hC4;
               11'd2:   const_byte = dl[15:8];
               11'd3:   const_byte = dl[7:0];
               default: const_byte = 8'h00;
            endcase
         ST_SOS:
            case (c)
               11'd0:   const_byte = 8'hFF;
               11'd1:   const_byte = 8'hDA;
               11'd3:   const_byte = 8'h0C;
               11'd4:   const_byte = 8'h03;
               11'd5:   const_byte = 8'h01;
               11'd7:   const_byte = 8'h02;
               11'd8:   const_byte = 8'h11;
               11'd9:   const_byte = 8'h03;
               11'd10:  const_byte = 8'h11;
               11'd12:  const_byte = 8'h3F;
               default: const_byte = 8'h00;
            endcase
         default: const_byte = 8'h00;
      endcase
   endfunction

   // Next-state, byte loading and address prefetch
   always_comb begin
      xfer_s      = out_en_r & OutReady;
      slot_free_s = ~out_en_r | OutReady;
      len_s       = seg_len(state_r, ht_len_r);
      tbl_s       = is_table(state_r, cnt_r, ht_len_r);
      byte_s      = tbl_s ? ((state_r == ST_DQT) ? QtData : HtData)
                          : const_byte(state_r, cnt_r, width_r, height_r, ht_len_r);
      state_s     = state_r;
      cnt_s       = cnt_r;
      out_data_s  = out_data_r;
      out_en_s    = out_en_r & ~OutReady;
      case (state_r)
         ST_SOI:  next_seg_s = ST_DQT;
         ST_DQT:  next_seg_s = ST_SOF;
         ST_SOF:  next_seg_s = (ht_len_r == 10'd0) ? ST_SOS : ST_DHT;
         ST_DHT:  next_seg_s = ST_SOS;
         ST_SOS:  next_seg_s = ST_WAIT;
         default: next_seg_s = ST_IDLE;
      endcase
      case (state_r)
         ST_IDLE:
            if (Start) begin
               state_s = ST_SOI;
               cnt_s   = 11'd0;
            end else begin
               state_s = ST_IDLE;
            end
         ST_WAIT:
            if (EndRequest) begin
               state_s = ST_EOI;
               cnt_s   = 11'd0;
            end else begin
               state_s = ST_WAIT;
            end
         ST_SOI, ST_DQT, ST_SOF, ST_DHT, ST_SOS, ST_EOI:
            if (cnt_r == len_s) begin
               // Last byte is in the output register; every following segment opens with FF
               if (xfer_s && (next_seg_s != ST_WAIT) && (next_seg_s != ST_IDLE)) begin
                  state_s    = next_seg_s;
                  out_data_s = 8'hFF;
                  out_en_s   = 1'b1;
                  cnt_s      = 11'd1;
               end else if (xfer_s) begin
                  state_s = next_seg_s;
                  cnt_s   = 11'd0;
               end else begin
                  state_s = state_r;
               end
            end else if (slot_free_s && (!tbl_s || fetched_r)) begin
               out_data_s = byte_s;
               out_en_s   = 1'b1;
               cnt_s      = cnt_r + 11'd1;
            end else begin
               cnt_s = cnt_r;
            end
         default: state_s = ST_IDLE;
      endcase
      qt_addr_s = qt_addr_r;
      ht_addr_s = ht_addr_r;
      if (state_s == ST_IDLE) begin
         qt_addr_s = 7'd0;
         ht_addr_s = 10'd0;
      end else if (is_table(state_s, cnt_s, ht_len_r) && (state_s == ST_DQT)) begin
         qt_addr_s = qt_index(cnt_s);
      end else if (is_table(state_s, cnt_s, ht_len_r)) begin
         ht_addr_s = ht_index(cnt_s);
      end else begin
         qt_addr_s = qt_addr_r;
      end
   end

   // State, output and address registers; image parameters latched on accepted Start
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 11'd0;
         out_data_r <= 8'd0;
         out_en_r   <= 1'b0;
         fetched_r  <= 1'b0;
         qt_addr_r  <= 7'd0;
         ht_addr_r  <= 10'd0;
         width_r    <= 16'd0;
         height_r   <= 16'd0;
         ht_len_r   <= 10'd0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         out_data_r <= out_data_s;
         out_en_r   <= out_en_s;
         // RAM/ROM data is valid once the address has been held across one edge
         fetched_r  <= (state_s == state_r) && (cnt_s == cnt_r);
         qt_addr_r  <= qt_addr_s;
         ht_addr_r  <= ht_addr_s;
         if ((state_r == ST_IDLE) && Start) begin
            width_r  <= InWidth;
            height_r <= InHeight;
            ht_len_r <= HtLength;
         end
      end
   end

   assign QtAddr     = qt_addr_r;
   assign HtAddr     = ht_addr_r;
   assign OutData    = out_data_r;
   assign OutEnable  = out_en_r;
   assign HeaderIdle = (state_r == ST_IDLE);
   assign HeaderDone = xfer_s && (state_r == ST_SOS) && (cnt_r == 11'd14);
   assign StreamDone = xfer_s && (state_r == ST_EOI) && (cnt_r == 11'd2);

endmodule

// File: tb/tb_jpeg_header_gen.sv
// Self-checking bench for jpeg_header_gen: expected byte streams are assembled from the
// segment definitions, with synchronous RAM/ROM models and random sink back-pressure.
module tb_jpeg_header_gen;
   logic        clk = 1'b0;
   logic        rst, Start, EndRequest, OutReady;
   logic [15:0] InWidth, InHeight;
   logic [9:0]  HtLength;
   logic [6:0]  QtAddr;
   logic [7:0]  QtData;
   logic [9:0]  HtAddr;
   logic [7:0]  HtData;
   logic [7:0]  OutData;
   logic        OutEnable, HeaderIdle, HeaderDone, StreamDone;

   jpeg_header_gen dut (
      .clk(clk), .rst(rst), .Start(Start), .InWidth(InWidth), .InHeight(InHeight),
      .HtLength(HtLength), .EndRequest(EndRequest), .QtAddr(QtAddr), .QtData(QtData),
      .HtAddr(HtAddr), .HtData(HtData), .OutData(OutData), .OutEnable(OutEnable),
      .OutReady(OutReady), .HeaderIdle(HeaderIdle), .HeaderDone(HeaderDone),
      .StreamDone(StreamDone)
   );

   always #5 clk = ~clk;

   logic [7:0] qt_mem [128];
   logic [7:0] ht_mem [1024];

   always @(posedge clk) begin
      QtData <= qt_mem[QtAddr];
      HtData <= ht_mem[HtAddr];
   end

   int          checks = 0;
   int          passes = 0;
   logic [7:0]  cap [$];
   logic [7:0]  exp_q [$];
   int          hd_cnt, hd_idx, sd_cnt, stall_err;
   int unsigned cyc = 0, hd_cyc = 0, start_cyc = 0;
   logic        ht_touched, prev_stall, rnd_mode, ready_level;
   logic [7:0]  prev_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   initial begin
      OutReady = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         OutReady = rnd_mode ? ($urandom_range(0, 99) < 30) : ready_level;
      end
   end

   // Sink monitor: captures transferred bytes, pulse positions and stall stability
   initial begin
      prev_stall = 1'b0;
      prev_data  = 8'd0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && (!OutEnable || (OutData !== prev_data))) stall_err++;
            prev_stall = OutEnable & ~OutReady;
            prev_data  = OutData;
            if (OutEnable && OutReady) cap.push_back(OutData);
            if (HeaderDone) begin
               hd_cnt++;
               hd_idx = cap.size() - 1;
               hd_cyc = cyc;
            end
            if (StreamDone) sd_cnt++;
            if (HtAddr != 10'd0) ht_touched = 1'b1;
         end
      end
   end

   task automatic build_expected(input logic [15:0] w, input logic [15:0] h, input logic [9:0] hl);
      logic [7:0]  sof_tail [10] = '{8'h03, 8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
      logic [7:0]  sos [14] = '{8'hFF, 8'hDA, 8'h00, 8'h0C, 8'h03, 8'h01, 8'h00, 8'h02, 8'h11, 8'h03, 8'h11, 8'h00, 8'h3F, 8'h00};
      logic [15:0] dl;
      exp_q.delete();
      exp_q.push_back(8'hFF); exp_q.push_back(8'hD8);
      exp_q.push_back(8'hFF); exp_q.push_back(8'hDB); exp_q.push_back(8'h00); exp_q.push_back(8'h84);
      exp_q.push_back(8'h00);
      for (int i = 0; i < 64; i++) exp_q.push_back(qt_mem[i]);
      exp_q.push_back(8'h01);
      for (int i = 64; i < 128; i++) exp_q.push_back(qt_mem[i]);
      exp_q.push_back(8'hFF); exp_q.push_back(8'hC0); exp_q.push_back(8'h00); exp_q.push_back(8'h11);
      exp_q.push_back(8'h08);
      exp_q.push_back(h[15:8]); exp_q.push_back(h[7:0]); exp_q.push_back(w[15:8]); exp_q.push_back(w[7:0]);
      foreach (sof_tail[i]) exp_q.push_back(sof_tail[i]);
      if (hl != 10'd0) begin
         dl = 16'(hl) + 16'd2;
         exp_q.push_back(8'hFF); exp_q.push_back(8'hC4);
         exp_q.push_back(dl[15:8]); exp_q.push_back(dl[7:0]);
         for (int i = 0; i < int'(hl); i++) exp_q.push_back(ht_mem[i]);
      end
      foreach (sos[i]) exp_q.push_back(sos[i]);
   endtask

   task automatic start_stream(input logic [15:0] w, input logic [15:0] h, input logic [9:0] hl);
      build_expected(w, h, hl);
      cap.delete();
      hd_cnt = 0; hd_idx = -1; sd_cnt = 0; stall_err = 0; ht_touched = 1'b0;
      @(posedge clk); #1;
      InWidth = w; InHeight = h; HtLength = hl; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      start_cyc = cyc;
      // Later input changes must not disturb the running stream
      InWidth = 16'($urandom); InHeight = 16'($urandom); HtLength = 10'($urandom);
   endtask

   task automatic wait_bytes(input string tag, input int n, input int budget);
      int k = 0;
      while ((cap.size() < n) && (k < budget)) begin
         @(posedge clk);
         k++;
      end
      check(tag, 32'(cap.size() >= n), 32'd1);
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_len"}, cap.size(), exp_q.size());
      for (int i = 0; (i < cap.size()) && (i < exp_q.size()); i++) check(tag, cap[i], exp_q[i]);
      check({tag, "_hdr_done_cnt"}, hd_cnt, 1);
      check({tag, "_hdr_done_idx"}, hd_idx, exp_q.size() - 1);
   endtask

   task automatic end_stream(input string tag);
      int n;
      n = cap.size();
      @(posedge clk); #1; EndRequest = 1'b1;
      @(posedge clk); #1; EndRequest = 1'b0;
      wait_bytes({tag, "_eoi_wait"}, n + 2, 200);
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (cap.size() >= n + 2) begin
         check({tag, "_eoi0"}, cap[n], 8'hFF);
         check({tag, "_eoi1"}, cap[n+1], 8'hD9);
      end
      check({tag, "_eoi_len"}, cap.size(), n + 2);
      check({tag, "_stream_done"}, sd_cnt, 1);
      check({tag, "_idle"}, HeaderIdle, 1'b1);
   endtask

   initial begin
      rst = 1'b1; Start = 1'b0; EndRequest = 1'b0;
      InWidth = 16'd0; InHeight = 16'd0; HtLength = 10'd0;
      rnd_mode = 1'b0; ready_level = 1'b1;
      for (int i = 0; i < 128; i++) qt_mem[i] = 8'(i);
      for (int i = 0; i < 1024; i++) ht_mem[i] = 8'($urandom);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_en", OutEnable, 1'b0);
      check("rst_out_data", OutData, 8'h00);
      check("rst_hdr_idle", HeaderIdle, 1'b1);
      check("rst_hdr_done", HeaderDone, 1'b0);
      check("rst_stream_done", StreamDone, 1'b0);
      check("rst_qt_addr", QtAddr, 7'd0);
      check("rst_ht_addr", HtAddr, 10'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Full header, sink always ready; table bytes must come at least every other cycle
      start_stream(16'h0140, 16'h00F0, 10'd418);
      check("ref_len", exp_q.size(), 591);
      wait_bytes("run1_wait", 591, 5000);
      repeat (5) @(posedge clk);
      @(negedge clk);
      compare_stream("run1");
      check("run1_throughput", 32'((hd_cyc - start_cyc) <= (45 + 2 * 546 + 4)), 32'd1);
      check("run1_in_wait", HeaderIdle, 1'b0);
      end_stream("run1");

      // Same header under random back-pressure
      rnd_mode = 1'b1;
      start_stream(16'h0140, 16'h00F0, 10'd418);
      wait_bytes("run2_wait", 591, 20000);
      repeat (5) @(posedge clk);
      @(negedge clk);
      compare_stream("run2");
      check("run2_stall_hold", stall_err, 0);
      end_stream("run2");
      rnd_mode = 1'b0;

      // No Huffman tables: SOF runs straight into SOS (2+134+19+14 bytes)
      for (int i = 0; i < 128; i++) qt_mem[i] = 8'($urandom);
      start_stream(16'($urandom), 16'($urandom), 10'd0);
      wait_bytes("run3_wait", 169, 2000);
      repeat (5) @(posedge clk);
      @(negedge clk);
      compare_stream("run3");
      check("run3_ht_untouched", ht_touched, 1'b0);
      end_stream("run3");

      // Reset while a DQT byte is stalled, then a fresh stream
      start_stream(16'($urandom), 16'($urandom), 10'd5);
      wait_bytes("run4_pre", 12, 500);
      ready_level = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("run4_stalled", OutEnable, 1'b1);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("run4_rst_out_en", OutEnable, 1'b0);
      check("run4_rst_idle", HeaderIdle, 1'b1);
      ready_level = 1'b1;
      rnd_mode = 1'b1;
      start_stream(16'($urandom), 16'($urandom), 10'($urandom_range(1, 60)));
      wait_bytes("run4_wait", exp_q.size(), 10000);
      repeat (5) @(posedge clk);
      @(negedge clk);
      compare_stream("run4");
      check("run4_stall_hold", stall_err, 0);
      end_stream("run4");
      rnd_mode = 1'b0;

      // Start during SOF and EndRequest during SOS are both ignored
      start_stream(16'($urandom), 16'($urandom), 10'd20);
      wait_bytes("run5_sof", 140, 1000);
      #1; Start = 1'b1;
      @(posedge clk); #1; Start = 1'b0;
      wait_bytes("run5_sos", exp_q.size() - 5, 1000);
      #1; EndRequest = 1'b1;
      @(posedge clk); #1; EndRequest = 1'b0;
      wait_bytes("run5_wait", exp_q.size(), 1000);
      repeat (10) @(posedge clk);
      @(negedge clk);
      compare_stream("run5");
      check("run5_held_in_wait", HeaderIdle, 1'b0);
      check("run5_no_eoi", sd_cnt, 0);
      end_stream("run5");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
